// File: rtl/parallax_checker_gen.sv
// parallax_checker_gen: VGA timing plus N-layer scrolling checkerboard; optional PARALLAX_DITHER_EN adds per-layer dither gating
module parallax_checker_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter int LAYERS    = 5,
    parameter logic [6*LAYERS-1:0] LAYER_COLORS = {6'b11_10_10, 6'b11_01_01, 6'b10_00_00, 6'b01_00_00, 6'b01_00_00},
    parameter int FRAME_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               step,
    input  logic               dir,
    input  logic [LAYERS-1:0]  layer_en,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [5:0]         rgb,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick
);
    localparam int H_MAX = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_MAX = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
    localparam int HW = $clog2(H_MAX + 1);
    localparam int VW = $clog2(V_MAX + 1);

    logic [HW-1:0]     hpos;
    logic [VW-1:0]     vpos;
    logic [13:0]       ox [LAYERS];
    logic [13:0]       oy [LAYERS];
    logic              step_pending;
    logic              h_end, v_end, tick, advance, vis, hs, vs;
    logic [LAYERS-1:0] hit;
    logic [5:0]        color;

    function automatic logic pick(input logic [9:0] v, input int b);
        return v[b];
    endfunction

    assign h_end   = hpos == HW'(H_MAX);
    assign v_end   = vpos == VW'(V_MAX);
    assign tick    = h_end && vpos == VW'(V_DISPLAY - 1);
    assign advance = tick && (run || step_pending || step);
    assign vis     = hpos < HW'(H_DISPLAY) && vpos < VW'(V_DISPLAY);
    assign hs      = hpos >= HW'(H_DISPLAY + H_FRONT) && hpos <= HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    assign vs      = vpos >= VW'(V_DISPLAY + V_BOTTOM) && vpos <= VW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    for (genvar k = 0; k < LAYERS; k++) begin : g_layer
        logic raw;
        assign raw = pick(10'(hpos) + ox[k][13:4], 8 - k) ^ pick(10'(vpos) + oy[k][13:4], 8 - k);
`ifdef PARALLAX_DITHER_EN
        logic gate;
        if (k == 0) begin : g_d0
            assign gate = vpos[1] ^ hpos[0];
        end else if (k == 1) begin : g_d1
            assign gate = ~vpos[0] ^ hpos[1];
        end else if (k == LAYERS - 1 && LAYERS >= 3) begin : g_dl
            assign gate = vpos[1] ^ hpos[0];
        end else begin : g_dn
            assign gate = 1'b1;
        end
        assign hit[k] = raw && layer_en[k] && gate;
`else
        assign hit[k] = raw && layer_en[k];
`endif
    end

    // Priority resolve: walk from the highest index down so the lowest hit layer wins
    always_comb begin
        color = '0;
        for (int k = LAYERS - 1; k >= 0; k--)
            if (hit[k]) color = LAYER_COLORS[6*(LAYERS-k)-1 -: 6];
    end

    // Raster position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos <= '0;
            vpos <= '0;
        end else begin
            hpos <= h_end ? '0 : hpos + 1'b1;
            if (h_end) vpos <= v_end ? '0 : vpos + 1'b1;
        end
    end

    // Frame counter, step latch and scroll offsets; offsets move only at the blanking update point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame        <= '0;
            step_pending <= 1'b0;
            for (int k = 0; k < LAYERS; k++) begin
                ox[k] <= '0;
                oy[k] <= '0;
            end
        end else begin
            step_pending <= !run && !advance && (step_pending || step);
            if (advance) begin
                frame <= dir ? frame - 1'b1 : frame + 1'b1;
                for (int k = 0; k < LAYERS; k++) begin
                    ox[k] <= dir ? ox[k] - 14'(256 >> k) : ox[k] + 14'(256 >> k);
                    oy[k] <= dir ? oy[k] - 14'(32 >> k) : oy[k] + 14'(32 >> k);
                end
            end
        end
    end

    // Registered outputs, all one cycle behind the raster position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            display_on <= 1'b0;
            rgb        <= '0;
            frame_tick <= 1'b0;
        end else begin
            hsync      <= hs;
            vsync      <= vs;
            display_on <= vis;
            rgb        <= vis ? color : '0;
            frame_tick <= tick;
        end
    end
endmodule

// File: tb/tb_parallax_checker_gen.sv
// tb_parallax_checker_gen: scoreboard bench for parallax_checker_gen on a reduced 100x12 raster
module tb_parallax_checker_gen;
    logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0, step = 1'b0, dir = 1'b0;
    logic [4:0] layer_en = '0;
    logic       hsync, vsync, display_on, frame_tick;
    logic [5:0] rgb;
    logic [9:0] frame;

    typedef struct { int pos; int sel; int val; } exp_t;
    exp_t  q[$];
    int    ecount = 0;
    int    total = 0;
    int    bad = 0;
    string names [6] = '{"hsync", "vsync", "display_on", "rgb", "frame", "frame_tick"};

    localparam int HS = 0, VS = 1, DO = 2, RGB = 3, FR = 4, TK = 5;

    parallax_checker_gen #(
        .H_DISPLAY(80), .H_FRONT(4), .H_SYNC(8), .H_BACK(8),
        .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .dir(dir), .layer_en(layer_en),
        .hsync(hsync), .vsync(vsync), .display_on(display_on), .rgb(rgb),
        .frame(frame), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // edges since reset release; output sampled after edge n shows raster position n-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else ecount <= ecount + 1;
    end

    function automatic int actual(input int sel);
        case (sel)
            HS:      return int'(hsync);
            VS:      return int'(vsync);
            DO:      return int'(display_on);
            RGB:     return int'(rgb);
            FR:      return int'(frame);
            default: return int'(frame_tick);
        endcase
    endfunction

    task automatic expect_at(input int pos, input int sel, input int val);
        exp_t e;
        int   i;
        e.pos = pos;
        e.sel = sel;
        e.val = val;
        i = 0;
        while (i < q.size() && q[i].pos <= pos) i++;
        q.insert(i, e);
    endtask

    // monitor: pops every expectation whose raster position is now on the outputs
    always @(negedge clk) begin
        exp_t e;
        int   p, a;
        p = ecount - 1;
        while (q.size() > 0 && q[0].pos <= p) begin
            e = q.pop_front();
            a = actual(e.sel);
            total++;
            if (e.pos < p) begin
                bad++;
                $display("FAIL %s pos=%0d skipped at pos=%0d", names[e.sel], e.pos, p);
            end else if (a != e.val) begin
                bad++;
                $display("FAIL %s pos=%0d got=0x%0h want=0x%0h", names[e.sel], e.pos, a, e.val);
            end
        end
    end

    task automatic wait_cnt(input int s);
        for (int i = 0; i < 20000 && ecount != s; i++) begin
            @(posedge clk);
            #1;
        end
        if (ecount != s) begin
            total++;
            bad++;
            $display("FAIL wait_cnt got=%0d want=%0d", ecount, s);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
            q.delete();
        end
    endtask

    task automatic reset_checks();
        for (int s = 0; s < 6; s++) expect_at(-1, s, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_phase(input logic r, input logic d, input logic [4:0] en);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        run = r;
        dir = d;
        layer_en = en;
        step = 1'b0;
        reset_checks();
        rst_n = 1'b1;
    endtask

    initial begin
        // sync timing, display window and frame tick with everything transparent
        start_phase(1'b0, 1'b0, 5'b00000);
        expect_at(0, DO, 1);     expect_at(0, HS, 0);     expect_at(50, RGB, 0);
        expect_at(79, DO, 1);    expect_at(80, DO, 0);    expect_at(83, HS, 0);
        expect_at(84, HS, 1);    expect_at(91, HS, 1);    expect_at(92, HS, 0);
        expect_at(183, HS, 0);   expect_at(184, HS, 1);   expect_at(500, DO, 1);
        expect_at(598, TK, 0);   expect_at(599, TK, 1);   expect_at(599, DO, 0);
        expect_at(599, VS, 0);   expect_at(600, TK, 0);   expect_at(600, FR, 0);
        expect_at(799, VS, 0);   expect_at(800, VS, 1);   expect_at(999, VS, 1);
        expect_at(1000, VS, 0);  expect_at(1200, DO, 1);  expect_at(1200, HS, 0);
        expect_at(1799, TK, 1);
        drain(2000);

        // free run forward, layers 2 and 4: priority and three frames of scroll
        start_phase(1'b1, 1'b0, 5'b10100);
        expect_at(0, RGB, 0);       expect_at(16, RGB, 6'h10);  expect_at(63, RGB, 6'h10);
        expect_at(64, RGB, 6'h20);  expect_at(164, RGB, 6'h20); expect_at(598, FR, 0);
        expect_at(599, FR, 1);      expect_at(599, TK, 1);      expect_at(1799, FR, 2);
        expect_at(2998, FR, 2);     expect_at(2999, FR, 3);     expect_at(2999, TK, 1);
        expect_at(3000, FR, 3);     expect_at(3000, TK, 0);     expect_at(3612, RGB, 0);
        expect_at(3613, RGB, 6'h10); expect_at(3650, RGB, 6'h10); expect_at(3655, RGB, 6'h20);
        expect_at(3677, RGB, 6'h20);
        drain(4000);

        // single-step: mid-frame request, idle frame, then step coincident with the tick
        start_phase(1'b0, 1'b0, 5'b10000);
        expect_at(15, RGB, 0);      expect_at(598, FR, 0);      expect_at(599, FR, 1);
        expect_at(1215, RGB, 6'h10); expect_at(1799, TK, 1);    expect_at(1800, FR, 1);
        expect_at(2998, FR, 1);     expect_at(2999, FR, 2);
        wait_cnt(300);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        wait_cnt(2999);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        drain(2000);

        // reverse from reset: frame wraps to all ones, offsets wrap downward
        start_phase(1'b1, 1'b1, 5'b10001);
        expect_at(0, RGB, 0);       expect_at(598, FR, 0);      expect_at(599, FR, 1023);
        expect_at(1200, RGB, 0);    expect_at(1201, RGB, 6'h10); expect_at(1216, RGB, 6'h3A);
        drain(2000);

        // reset asserted mid-line in frame 1, then restart from the origin
        start_phase(1'b1, 1'b0, 5'b10000);
        expect_at(1248, DO, 1);
        expect_at(1248, RGB, 6'h10);
        expect_at(1248, FR, 1);
        wait_cnt(1250);
        rst_n = 1'b0;
        reset_checks();
        rst_n = 1'b1;
        expect_at(0, DO, 1);   expect_at(0, FR, 0);   expect_at(16, RGB, 6'h10);
        expect_at(83, HS, 0);  expect_at(84, HS, 1);
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
